rr_stream_arbiter: RTL and testbench
====================================

// Module: rr_stream_arbiter
// PURPOSE
// - Shares one valid/ready byte-stream datapath among N requesters (round-robin, packet-locked).
// - Sits upstream of the backward skid buffer stage.
// - Registers the winning stream into a one-entry forward output stage.
// - Tags each beat with the source id so downstream logic can demultiplex.
// PARAMETERS
// L        8  data width per beat
// N        4  number of requesters (>=1)
// IDW      2  id width, must equal max(1,clog2(N))
// HOLD_PKT 1  1: grant held until beat with req_last accepted; 0: re-arbitrate after every beat
// PORTS
// clk        in   1    rising-edge clock
// rst        in   1    asynchronous active-low reset
// req_valid  in   N    per-requester beat valid
// req_ready  out  N    per-requester beat accept, one-hot or zero
// req_data   in   N*L  requester i occupies bits [i*L +: L]
// req_last   in   N    last beat of packet
// out_valid  out  1    output beat valid (registered)
// out_ready  in   1    downstream accept
// out_data   out  L    output beat (registered)
// out_last   out  1    last flag of output beat (registered)
// out_id     out  IDW  source requester of output beat (registered)
// busy       out  1    state==LOCK or out_valid
// BEHAVIOUR
// - Reset (rst=0, async, dominant at any time, incl. mid-packet):
//   - out_valid/out_data/out_last/out_id = 0, req_ready = 0
//   - state = IDLE, grant = 0, rr pointer ptr = N-1, so requester 0 wins first
// - FSM states IDLE, LOCK:
//   - IDLE: if |req_valid: grant <= first valid index searching ptr+1, ptr+2, ... (mod N); -> LOCK.
//     Otherwise stay in IDLE.
//   - LOCK: req_ready[grant] = (!out_valid || out_ready); all other req_ready bits = 0.
//   - Accept = req_valid[grant] && req_ready[grant]. On accept the output registers load
//     data/last/id and out_valid <= 1.
//   - Leave LOCK (-> IDLE, ptr <= grant) on accept when req_last[grant]=1, or on any accept
//     when HOLD_PKT=0.
// - Output stage: out_valid clears on (out_valid && out_ready && !accept).
//   - Simultaneous output drain and new accept keeps out_valid=1 (full throughput within a packet).
// - Latency: req_valid rises in cycle 0 (IDLE) -> grant registered, req_ready high in cycle 1 -> out_valid in cycle 2.
// - One bubble cycle per grant (the IDLE arbitration cycle); throughput 1 beat/cycle inside a packet.
// - Backpressure: while out_valid && !out_ready, out_* are held stable and req_ready = 0; no beat
//   is lost or duplicated.
// - Granted requester dropping req_valid without a handshake: grant is held; no timeout.
// - Non-granted requesters never see req_ready=1. New requests during LOCK wait for the next IDLE cycle.
// - ptr update and a new request in the same cycle: the new arbitration uses the updated ptr on the
//   following IDLE cycle.
// - N=1: always grants 0; same 1-bubble-per-packet rule.
// - req_ready is combinational from out_ready and state; no combinational path from req_valid to req_ready.
// STRUCTURE
// - Package stream_arb_pkg:
//   - state encoding localparams ST_IDLE=1'b0, ST_LOCK=1'b1
//   - clog2 function used for IDW checking
// - Sub-module rr_priority_pick (combinational):
//   - in:  req[N], ptr[IDW]
//   - out: any, idx[IDW]
//   - function: rotate by ptr+1, priority-encode, un-rotate
// - Top level holds FSM, grant/ptr registers, data mux, and output register stage.
// TESTING
// - Reset: assert rst=0 mid-packet with out_valid=1 -> out_valid=0, req_ready=0 immediately.
//   After release with all 4 valid, first out_id=0.
// - Fairness: all 4 req_valid=1, single-beat packets (last=1), out_ready=1 -> out_id sequence
//   0,1,2,3,0,..., one beat every 2 cycles.
// - Packet lock: req1 sends 3 beats (last on 3rd), req2 valid throughout -> req_ready[2]=0 until
//   req1 last accepted; out_id 1,1,1,2.
// - Backpressure: out_ready=0 for 5 cycles while out_valid=1, out_data=8'hA5 -> data held at A5,
//   req_ready=0; after release no loss/dup (scoreboard).
// - HOLD_PKT=0: req0 4-beat packet, req3 4-beat packet, both valid -> out_id 0,3,0,3,0,3,0,3.
// - Lone requester: only req2 valid, back-to-back 1-beat packets -> grant stays 2, exactly one idle
//   cycle between beats.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
//
// Shared definitions for the round-robin stream arbiter.
//   arb_state_t : arbiter FSM encoding (ST_IDLE = 1'b0, ST_LOCK = 1'b1)
//   clog2()     : ceiling log2, used to check the id width parameter
//   id_width()  : id width required for a given requester count (min 1)
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,   // arbitration cycle, no requester granted
        ST_LOCK = 1'b1    // grant held by one requester
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A single requester still needs one id bit on the output.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//
// Combinational round-robin pick. Searches req starting at ptr+1 and wrapping
// modulo N; the first set bit wins.
//   req [N]   : request vector
//   ptr [IDW] : index of the previous winner (search starts after it)
//   any       : at least one request present
//   idx [IDW] : index of the winning request (0 when any = 0)
// -----------------------------------------------------------------------------
module rr_priority_pick
    import stream_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    // Equivalent to rotate-by-(ptr+1), priority-encode, un-rotate: walk the
    // candidates from the farthest (ptr+N) to the nearest (ptr+1) so that the
    // last hit written, i.e. the nearest one after ptr, wins.
    always_comb begin
        any      = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = N; i >= 1; i--) begin
            cand     = (int'(ptr) + i) % N;
            cand_idx = IDW'(cand);
            if (req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
//
// Shares one valid/ready byte-stream datapath among N requesters using a
// packet-locked round-robin grant, and registers the winning beat into a
// one-entry forward output stage tagged with the source id.
//
// Handshake: a beat moves across an interface in the cycle where both valid
// and ready are high at the rising clock edge. Valid, once raised by a
// source, is expected to stay up until accepted; ready on this block's
// requester side never depends on req_valid.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   req_valid  : [N]   per-requester beat valid
//   req_ready  : [N]   per-requester accept, one-hot or zero
//   req_data   : [N*L] requester i on bits [i*L +: L]
//   req_last   : [N]   last beat of packet
//   out_valid  : output beat valid (registered)
//   out_ready  : downstream accept
//   out_data   : [L]   output beat (registered)
//   out_last   : last flag of output beat (registered)
//   out_id     : [IDW] source requester of output beat (registered)
//   busy       : grant locked or output stage occupied
// -----------------------------------------------------------------------------
module rr_stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int L        = 8,
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int HOLD_PKT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*L-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L-1:0]     out_data,
    output logic             out_last,
    output logic [IDW-1:0]   out_id,
    output logic             busy
);

    if (IDW != id_width(N)) begin : g_bad_idw
        $error("rr_stream_arbiter: IDW must equal max(1, clog2(N))");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t     state_q,     state_d;
    logic [IDW-1:0] grant_q,     grant_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [L-1:0]   out_data_q,  out_data_d;
    logic           out_last_q,  out_last_d;
    logic [IDW-1:0] out_id_q,    out_id_d;

    // ------------------------------------------------------------------
    // Round-robin pick, only consumed in the IDLE cycle
    // ------------------------------------------------------------------
    logic           pick_any;
    logic [IDW-1:0] pick_idx;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // ------------------------------------------------------------------
    // Datapath select and handshake
    // ------------------------------------------------------------------
    logic         can_load;
    logic         accept;
    logic [L-1:0] sel_data;
    logic         sel_last;
    logic         leave_lock;

    always_comb begin
        // The output stage can take a beat if it is empty or draining now.
        can_load = !out_valid_q || out_ready;

        req_ready = '0;
        if (state_q == ST_LOCK && can_load) begin
            req_ready[grant_q] = 1'b1;
        end

        sel_data = req_data[int'(grant_q)*L +: L];
        sel_last = req_last[grant_q];

        accept     = (state_q == ST_LOCK) && req_valid[grant_q] && can_load;
        leave_lock = accept && (sel_last || (HOLD_PKT == 0));
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, grant/pointer and output stage
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // The pointer only moves when the grant is released, so a
                // request arriving now is arbitrated against the new pointer
                // in the following IDLE cycle.
                if (leave_lock) begin
                    state_d = ST_IDLE;
                    ptr_d   = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A simultaneous drain and load keeps the stage full, giving one
        // beat per cycle inside a packet.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_id_d    = grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            // Starting the pointer at N-1 makes requester 0 win first.
            ptr_q       <= IDW'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q == ST_LOCK) || out_valid_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
module tb_rr_stream_arbiter;

    localparam int L   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: packet-locked instance, index 1: per-beat arbitration instance
    logic [N-1:0]   req_valid [2];
    logic [N-1:0]   req_ready [2];
    logic [N*L-1:0] req_data  [2];
    logic [N-1:0]   req_last  [2];
    logic           out_valid [2];
    logic           out_ready [2];
    logic [L-1:0]   out_data  [2];
    logic           out_last  [2];
    logic [IDW-1:0] out_id    [2];
    logic           busy      [2];

    rr_stream_arbiter #(.L(L), .N(N), .IDW(IDW), .HOLD_PKT(1)) dut_hold (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_data  (req_data[0]),
        .req_last  (req_last[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .out_last  (out_last[0]),
        .out_id    (out_id[0]),
        .busy      (busy[0])
    );

    rr_stream_arbiter #(.L(L), .N(N), .IDW(IDW), .HOLD_PKT(0)) dut_beat (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_data  (req_data[1]),
        .req_last  (req_last[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .out_last  (out_last[1]),
        .out_id    (out_id[1]),
        .busy      (busy[1])
    );

    // ------------------------------------------------------------------
    // Source queues ({last, data}), captured output beats ({id, last, data})
    // ------------------------------------------------------------------
    logic [8:0]  src_q [2*N][$];
    logic [10:0] got_q [2][$];
    int          got_t [2][$];
    logic [10:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive();
        logic [8:0] b;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[d*N+i].size() != 0) begin
                    b = src_q[d*N+i][0];
                    req_valid[d][i]       = 1'b1;
                    req_data[d][i*L +: L] = b[7:0];
                    req_last[d][i]        = b[8];
                end else begin
                    req_valid[d][i]       = 1'b0;
                    req_data[d][i*L +: L] = '0;
                    req_last[d][i]        = 1'b0;
                end
            end
        end
    endtask

    // One clock: handshakes and output beats are sampled on the falling
    // edge, sources advance 1 time unit after the rising edge.
    task automatic step();
        logic [N-1:0] hs [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            hs[d] = req_valid[d] & req_ready[d];
            if (out_valid[d] && out_ready[d]) begin
                got_q[d].push_back({out_id[d], out_last[d], out_data[d]});
                got_t[d].push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (hs[d][i]) void'(src_q[d*N+i].pop_front());
            end
        end
        drive();
    endtask

    task automatic clear_all();
        for (int k = 0; k < 2*N; k++) src_q[k].delete();
        for (int d = 0; d < 2; d++) begin
            got_q[d].delete();
            got_t[d].delete();
        end
        exp_q.delete();
    endtask

    task automatic wait_got(input int d, input int cnt, input int limit, output bit ok);
        int k;
        k = 0;
        while (got_q[d].size() < cnt && k < limit) begin
            step();
            k++;
        end
        ok = (got_q[d].size() >= cnt);
    endtask

    task automatic drain(input int limit, output bit ok);
        int  k;
        bit  pending;
        k = 0;
        ok = 1'b0;
        while (k < limit) begin
            pending = out_valid[0] || out_valid[1];
            for (int j = 0; j < 2*N; j++) if (src_q[j].size() != 0) pending = 1'b1;
            if (!pending) begin
                ok = 1'b1;
                break;
            end
            step();
            k++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid[0]); end
        n_vec++; if (req_ready[0] !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready[0]); end
        n_vec++; if (out_data[0] !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h want 00", out_data[0]); end
        n_vec++; if (out_id[0] !== 2'd0) begin n_err++; $display("FAIL rst_out_id: got %0d want 0", out_id[0]); end
        n_vec++; if (out_last[0] !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", out_last[0]); end
        n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
        n_vec++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL rst_out_valid_beat: got %b want 0", out_valid[1]); end
        rst = 1'b1;
        step();
        n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy[0]); end
    endtask

    task automatic test_latency();
        bit ok;
        clear_all();
        src_q[1].push_back({1'b1, 8'h11});
        drive();
        // cycle 0: IDLE, arbitration only
        n_vec++; if (req_ready[0] !== 4'b0000) begin n_err++; $display("FAIL lat_c0_ready: got %b want 0000", req_ready[0]); end
        step();
        // cycle 1: grant registered, ready towards requester 1
        n_vec++; if (req_ready[0] !== 4'b0010) begin n_err++; $display("FAIL lat_c1_ready: got %b want 0010", req_ready[0]); end
        n_vec++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL lat_c1_valid: got %b want 0", out_valid[0]); end
        n_vec++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL lat_c1_busy: got %b want 1", busy[0]); end
        step();
        // cycle 2: beat in the output stage
        n_vec++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL lat_c2_valid: got %b want 1", out_valid[0]); end
        n_vec++; if ({out_id[0], out_last[0], out_data[0]} !== {2'd1, 1'b1, 8'h11}) begin
            n_err++; $display("FAIL lat_c2_beat: got %h want %h", {out_id[0], out_last[0], out_data[0]}, {2'd1, 1'b1, 8'h11});
        end
        n_vec++; if (req_ready[0] !== 4'b0000) begin n_err++; $display("FAIL lat_c2_ready: got %b want 0000", req_ready[0]); end
        drain(20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL lat_drain: timeout got 0 want 1"); end
    endtask

    task automatic test_fairness();
        bit         ok;
        int         bad;
        logic [10:0] act;
        pulse_reset();
        clear_all();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                src_q[i].push_back({1'b1, 8'(i*16 + r)});
                exp_q.push_back({2'(i), 1'b1, 8'(i*16 + r)});
            end
        end
        drive();
        wait_got(0, 8, 60, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fair_timeout: got %0d beats want 8", got_q[0].size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            act = (j < got_q[0].size()) ? got_q[0][j] : 11'bx;
            n_vec++; if (act !== exp_q[j]) begin n_err++; $display("FAIL fair_beat%0d: got %h want %h", j, act, exp_q[j]); end
        end
        bad = 0;
        for (int j = 1; j < got_t[0].size(); j++) if (got_t[0][j] - got_t[0][j-1] != 2) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL fair_spacing: got %0d gaps not 2 want 0", bad); end
        drain(20, ok);
    endtask

    task automatic test_packet_lock();
        bit          ok;
        int          viol;
        int          k;
        logic [10:0] act;
        clear_all();
        src_q[1].push_back({1'b0, 8'h10});
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b1, 8'h12});
        src_q[2].push_back({1'b1, 8'h20});
        exp_q.push_back({2'd1, 1'b0, 8'h10});
        exp_q.push_back({2'd1, 1'b0, 8'h11});
        exp_q.push_back({2'd1, 1'b1, 8'h12});
        exp_q.push_back({2'd2, 1'b1, 8'h20});
        drive();
        viol = 0;
        k = 0;
        while (got_q[0].size() < 4 && k < 40) begin
            if (src_q[1].size() != 0 && req_ready[0][2] !== 1'b0) viol++;
            step();
            k++;
        end
        n_vec++; if (viol != 0) begin n_err++; $display("FAIL lock_ready2: got %0d cycles with ready want 0", viol); end
        for (int j = 0; j < exp_q.size(); j++) begin
            act = (j < got_q[0].size()) ? got_q[0][j] : 11'bx;
            n_vec++; if (act !== exp_q[j]) begin n_err++; $display("FAIL lock_beat%0d: got %h want %h", j, act, exp_q[j]); end
        end
        drain(20, ok);
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          k;
        logic [10:0] act;
        clear_all();
        out_ready[0] = 1'b0;
        src_q[0].push_back({1'b0, 8'hA5});
        src_q[0].push_back({1'b0, 8'h5A});
        src_q[0].push_back({1'b1, 8'h3C});
        exp_q.push_back({2'd0, 1'b0, 8'hA5});
        exp_q.push_back({2'd0, 1'b0, 8'h5A});
        exp_q.push_back({2'd0, 1'b1, 8'h3C});
        drive();
        k = 0;
        while (out_valid[0] !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        n_vec++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL bp_fill: got %b want 1", out_valid[0]); end
        for (int c = 0; c < 5; c++) begin
            step();
            n_vec++; if (out_data[0] !== 8'hA5 || out_valid[0] !== 1'b1) begin
                n_err++; $display("FAIL bp_hold%0d: got %b/%h want 1/a5", c, out_valid[0], out_data[0]);
            end
            n_vec++; if (req_ready[0] !== 4'b0000) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready[0]); end
        end
        out_ready[0] = 1'b1;
        wait_got(0, 3, 20, ok);
        drain(20, ok);
        repeat (3) step();
        n_vec++; if (got_q[0].size() != 3) begin n_err++; $display("FAIL bp_count: got %0d beats want 3", got_q[0].size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            act = (j < got_q[0].size()) ? got_q[0][j] : 11'bx;
            n_vec++; if (act !== exp_q[j]) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", j, act, exp_q[j]); end
        end
    endtask

    task automatic test_hold_pkt0();
        bit          ok;
        logic [10:0] act;
        clear_all();
        for (int b = 0; b < 4; b++) begin
            src_q[N+0].push_back({b == 3, 8'(8'h00 + b)});
            src_q[N+3].push_back({b == 3, 8'(8'h30 + b)});
            exp_q.push_back({2'd0, b == 3, 8'(8'h00 + b)});
            exp_q.push_back({2'd3, b == 3, 8'(8'h30 + b)});
        end
        drive();
        wait_got(1, 8, 80, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL beat_timeout: got %0d beats want 8", got_q[1].size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            act = (j < got_q[1].size()) ? got_q[1][j] : 11'bx;
            n_vec++; if (act !== exp_q[j]) begin n_err++; $display("FAIL beat_interleave%0d: got %h want %h", j, act, exp_q[j]); end
        end
        drain(20, ok);
    endtask

    task automatic test_lone();
        bit          ok;
        int          bad;
        logic [10:0] act;
        clear_all();
        for (int b = 0; b < 3; b++) begin
            src_q[2].push_back({1'b1, 8'(8'h70 + b)});
            exp_q.push_back({2'd2, 1'b1, 8'(8'h70 + b)});
        end
        drive();
        wait_got(0, 3, 30, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL lone_timeout: got %0d beats want 3", got_q[0].size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            act = (j < got_q[0].size()) ? got_q[0][j] : 11'bx;
            n_vec++; if (act !== exp_q[j]) begin n_err++; $display("FAIL lone_beat%0d: got %h want %h", j, act, exp_q[j]); end
        end
        bad = 0;
        for (int j = 1; j < got_t[0].size(); j++) if (got_t[0][j] - got_t[0][j-1] != 2) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL lone_spacing: got %0d gaps not 2 want 0", bad); end
        drain(20, ok);
    endtask

    task automatic test_reset_mid_packet();
        bit          ok;
        int          k;
        logic [10:0] act;
        clear_all();
        out_ready[0] = 1'b0;
        src_q[1].push_back({1'b0, 8'h91});
        src_q[1].push_back({1'b0, 8'h92});
        src_q[1].push_back({1'b1, 8'h93});
        drive();
        k = 0;
        while (out_valid[0] !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        n_vec++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL rmid_fill: got %b want 1", out_valid[0]); end
        // Assert reset between clock edges; it must take effect at once.
        #3;
        rst = 1'b0;
        #1;
        n_vec++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", out_valid[0]); end
        n_vec++; if (req_ready[0] !== 4'b0000) begin n_err++; $display("FAIL rmid_ready: got %b want 0000", req_ready[0]); end
        n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy[0]); end
        n_vec++; if (out_data[0] !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", out_data[0]); end
        clear_all();
        for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'(8'hC0 + i)});
        drive();
        #2;
        rst = 1'b1;
        out_ready[0] = 1'b1;
        wait_got(0, 4, 30, ok);
        act = (got_q[0].size() > 0) ? got_q[0][0] : 11'bx;
        n_vec++; if (act !== {2'd0, 1'b1, 8'hC0}) begin n_err++; $display("FAIL rmid_first: got %h want %h", act, {2'd0, 1'b1, 8'hC0}); end
        n_vec++; if (got_q[0].size() != 4) begin n_err++; $display("FAIL rmid_count: got %0d beats want 4", got_q[0].size()); end
        drain(20, ok);
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '0;
            req_data[d]  = '0;
            req_last[d]  = '0;
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_latency();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_hold_pkt0();
        test_lone();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
